// File: rtl/logic_unit_seq.sv
// Slice-serial AND/OR/XOR/PASS-A logic unit with optional inversion and result flags.
// One command at a time: accept in IDLE, SLICE bits per cycle in RUN, hold result in DONE.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             inv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("logic_unit_seq: WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic              inv_q, inv_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              zero_q, zero_d;
  logic              ones_q, ones_d;
  logic              parity_q, parity_d;

  logic              accept;
  logic              last_slice;
  logic [SLICE-1:0]  a_sl, b_sl, res_sl;

  assign accept     = in_valid & in_ready;
  assign last_slice = (cnt_q == CntW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)     state_d = StRun;
      StRun:  if (last_slice) state_d = StDone;
      StDone: if (out_ready)  state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Handshake outputs are pure functions of state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Current slice of the registered operands
  always_comb begin
    a_sl   = a_q[int'(cnt_q) * SLICE +: SLICE];
    b_sl   = b_q[int'(cnt_q) * SLICE +: SLICE];
    res_sl = '0;
    unique case (op_q)
      2'b00: res_sl = a_sl & b_sl;
      2'b01: res_sl = a_sl | b_sl;
      2'b10: res_sl = a_sl ^ b_sl;
      2'b11: res_sl = a_sl;
    endcase
    res_sl = res_sl ^ {SLICE{inv_q}};
  end

  // Datapath next-state: capture on accept, accumulate one slice per RUN cycle
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zero_d   = zero_q;
    ones_d   = ones_q;
    parity_d = parity_q;
    if (accept) begin
      a_d      = a;
      b_d      = b;
      op_d     = op;
      inv_d    = inv;
      cnt_d    = '0;
      out_d    = '0;
      zero_d   = 1'b1;
      ones_d   = 1'b1;
      parity_d = 1'b0;
    end else if (state_q == StRun) begin
      out_d[int'(cnt_q) * SLICE +: SLICE] = res_sl;
      zero_d   = zero_q & (res_sl == '0);
      ones_d   = ones_q & (res_sl == '1);
      parity_d = parity_q ^ (^res_sl);
      if (!last_slice) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      inv_q    <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      ones_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      inv_q    <= inv_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      ones_q   <= ones_d;
      parity_q <= parity_d;
    end
  end

  assign out    = out_q;
  assign zero   = zero_q;
  assign ones   = ones_q;
  assign parity = parity_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: three builds (SLICE 8, 32, 4) sharing operand buses,
// checked against a whole-word behavioural model.
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        inv = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b0;

  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic [31:0] ow [3];
  logic        zw [3];
  logic        onw[3];
  logic        pw [3];

  int          lat_n [3] = '{4, 1, 8};
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] exp_out;
  logic        exp_zero, exp_ones, exp_par;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(op), .inv(inv),
    .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .out(ow[0]), .zero(zw[0]),
    .ones(onw[0]), .parity(pw[0])
  );
  logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(op), .inv(inv),
    .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .out(ow[1]), .zero(zw[1]),
    .ones(onw[1]), .parity(pw[1])
  );
  logic_unit_seq #(.WIDTH(32), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op(op), .inv(inv),
    .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .out(ow[2]), .zero(zw[2]),
    .ones(onw[2]), .parity(pw[2])
  );

  function automatic logic [31:0] model(input logic [1:0] o, input logic i,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (o)
      2'd0:    r = x & y;
      2'd1:    r = x | y;
      2'd2:    r = x ^ y;
      default: r = x;
    endcase
    return i ? ~r : r;
  endfunction

  // Accept one command on instance sel and wait for its result; checks latency and result.
  task automatic issue(input int sel, input logic [1:0] o, input logic i,
                       input logic [31:0] x, input logic [31:0] y);
    int lat;
    exp_out  = model(o, i, x, y);
    exp_zero = (exp_out == 32'h0);
    exp_ones = (exp_out == 32'hFFFF_FFFF);
    exp_par  = ^exp_out;
    n_checks++;
    if (ir[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready[%0d]: got %b want 1", sel, ir[sel]);
    end
    op = o; inv = i; a = x; b = y; iv[sel] = 1'b1;
    @(negedge clk);
    iv[sel] = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom); inv = 1'($urandom);
    n_checks++;
    if (ir[sel] !== 1'b0) begin
      n_fail++;
      $display("FAIL run_ready[%0d]: got %b want 0", sel, ir[sel]);
    end
    lat = 0;
    while (ov[sel] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != lat_n[sel]) begin
      n_fail++;
      $display("FAIL latency[%0d]: got %0d want %0d", sel, lat, lat_n[sel]);
    end
    n_checks++;
    if (ow[sel] !== exp_out || zw[sel] !== exp_zero || onw[sel] !== exp_ones ||
        pw[sel] !== exp_par) begin
      n_fail++;
      $display("FAIL result[%0d]: got out=%h z=%b o=%b p=%b want out=%h z=%b o=%b p=%b",
               sel, ow[sel], zw[sel], onw[sel], pw[sel], exp_out, exp_zero, exp_ones, exp_par);
    end
  endtask

  // Hold DONE for stall cycles, then handshake and confirm return to IDLE.
  task automatic retire(input int sel, input int stall);
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      n_checks++;
      if (ov[sel] !== 1'b1 || ir[sel] !== 1'b0 || ow[sel] !== exp_out || zw[sel] !== exp_zero ||
          onw[sel] !== exp_ones || pw[sel] !== exp_par) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b r=%b out=%h want v=1 r=0 out=%h",
                 sel, ov[sel], ir[sel], ow[sel], exp_out);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (ov[sel] !== 1'b0 || ir[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_idle[%0d]: got v=%b r=%b want v=0 r=1", sel, ov[sel], ir[sel]);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (ir[s] !== 1'b1 || ov[s] !== 1'b0 || ow[s] !== 32'h0 || zw[s] !== 1'b0 ||
          onw[s] !== 1'b0 || pw[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got r=%b v=%b out=%h z=%b o=%b p=%b want 1 0 0 0 0 0",
                 s, ir[s], ov[s], ow[s], zw[s], onw[s], pw[s]);
      end
    end
  endtask

  task automatic test_vectors();
    issue(0, 2'd0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    n_checks++;
    if (ow[0] !== 32'h00F0_1234 || zw[0] !== 1'b0 || onw[0] !== 1'b0 || pw[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_and: got %h %b%b%b want 00f01234 001", ow[0], zw[0], onw[0], pw[0]);
    end
    retire(0, 0);
    issue(0, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    n_checks++;
    if (ow[0] !== 32'hFFFF_FFFF || zw[0] !== 1'b0 || onw[0] !== 1'b1 || pw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_xnor: got %h %b%b%b want ffffffff 010", ow[0], zw[0], onw[0], pw[0]);
    end
    retire(0, 1);
    issue(0, 2'd1, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (ow[0] !== 32'h0 || zw[0] !== 1'b1 || onw[0] !== 1'b0 || pw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_or0: got %h %b%b%b want 00000000 100", ow[0], zw[0], onw[0], pw[0]);
    end
    retire(0, 0);
    issue(0, 2'd3, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
    n_checks++;
    if (ow[0] !== 32'h0000_0001 || zw[0] !== 1'b0 || onw[0] !== 1'b0 || pw[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_pass: got %h %b%b%b want 00000001 001", ow[0], zw[0], onw[0], pw[0]);
    end
    retire(0, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    issue(0, 2'd2, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F);
    held = exp_out;
    for (int k = 0; k < 5; k++) begin
      iv[0] = (k == 2);
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 2'd1;
      @(negedge clk);
      n_checks++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || ow[0] !== held || zw[0] !== exp_zero ||
          onw[0] !== exp_ones || pw[0] !== exp_par) begin
        n_fail++;
        $display("FAIL bp_hold: got v=%b r=%b out=%h want v=1 r=0 out=%h", ov[0], ir[0], ow[0],
                 held);
      end
    end
    iv[0] = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", ov[0], ir[0]);
    end
    for (int k = 0; k < 10; k++) @(negedge clk);
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_not_queued: got v=%b r=%b want v=0 r=1", ov[0], ir[0]);
    end
    issue(0, 2'd0, 1'b1, 32'hA5A5_5A5A, 32'hFF00_FF00);
    retire(0, 0);
  endtask

  task automatic test_reset_mid_op();
    op = 2'd1; inv = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || ow[0] !== 32'h0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abort: got v=%b out=%h r=%b want v=0 out=0 r=1", ov[0], ow[0], ir[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b r=%b want v=0 r=1", ov[0], ir[0]);
    end
    issue(0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_FFFF);
    n_checks++;
    if (ow[0] !== 32'h0000_FFFF || pw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_next: got %h p=%b want 0000ffff p=0", ow[0], pw[0]);
    end
    retire(0, 0);
  endtask

  task automatic test_slice_builds();
    for (int s = 1; s < 3; s++) begin
      issue(s, 2'd0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      n_checks++;
      if (ow[s] !== 32'h00F0_1234 || zw[s] !== 1'b0 || onw[s] !== 1'b0 || pw[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL build_vec[%0d]: got %h %b%b%b want 00f01234 001", s, ow[s], zw[s],
                 onw[s], pw[s]);
      end
      retire(s, 2);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] x, y;
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 2);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = ~x;
        1: y = x;
        2: x = 32'h0;
        default: ;
      endcase
      issue(sel, 2'($urandom), 1'($urandom), x, y);
      retire(sel, $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) iv[s] = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_op();
    test_slice_builds();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Slice-serial, handshaked successor of the combinational inverting logic unit for the iCE40 ALU datapath. It computes AND/OR/XOR/PASS-A with optional output inversion on a WIDTH-bit operand pair, SLICE bits per cycle, so wide words fit a narrow LUT budget. It also produces zero, all-ones and parity flags. It sits between the ALU operand registers and the result writeback mux, using valid/ready on both sides.

## Interface
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits processed per cycle. WIDTH % SLICE != 0 is an elaboration error. N = WIDTH/SLICE.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  block accepts a command.
- op  in  2  00 AND, 01 OR, 10 XOR, 11 PASS A (b ignored).
- inv  in  1  invert the result of op bitwise.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  downstream accepts the result.
- out  out  WIDTH  result.
- zero  out  1  out == 0.
- ones  out  1  out == all ones.
- parity  out  1  XOR-reduction of out (odd number of ones = 1).

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register a, b, op and inv, clear slice counter cnt and flag accumulators, then go to RUN.
- RUN:
  - Each cycle, compute slice cnt (bits cnt*SLICE+SLICE-1 : cnt*SLICE) as (a op b) ^ {SLICE{inv}}.
  - Write that slice into out.
  - Update the accumulators: zero &= (slice == 0), ones &= (slice == all ones), parity ^= ^slice.
  - When cnt == N-1, go to DONE. Otherwise increment cnt.
  - in_ready = 0. in_valid is ignored and not queued.
- DONE:
  - out_valid = 1. out and the flags are held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 for the whole DONE state, including the handshake cycle.
- Operand registers are sampled only at the accept edge. Input changes afterwards do not affect the result in flight.
- Slices not yet processed read 0 on out. The value is not observable, since out_valid = 0 until DONE.
- Reset values: in_ready = 1 (state IDLE), out_valid = 0, out = 0, zero = 0, ones = 0, parity = 0, cnt = 0.
- Reset mid-operation (RUN or DONE) aborts immediately and asynchronously. No out_valid is produced for the aborted command.

## Timing
- Accept edge is E0. RUN occupies edges E1..EN (slice k written at E(k+1)). out_valid rises after EN, so latency is N cycles from acceptance.
- With SLICE == WIDTH (N = 1), out_valid is high in the cycle after acceptance.
- Minimum command period is N+2 cycles: accept, N RUN cycles, DONE with out_ready = 1, IDLE.
- out_ready held low stalls DONE indefinitely. out, zero, ones and parity stay unchanged.
- out_ready asserted while not in DONE has no effect.
- Flags are valid only while out_valid = 1.

## Test plan
- WIDTH=32, SLICE=8: a=0xF0F01234, b=0x0FF0FFFF, op=AND, inv=0 -> out=0x00F01234, zero=0, ones=0, parity=1; out_valid exactly 4 cycles after accept.
- op=XOR, a=b=0xDEADBEEF, inv=1 -> out=0xFFFFFFFF, ones=1, zero=0, parity=0.
- op=OR, a=b=0, inv=0 -> out=0, zero=1, ones=0, parity=0. Then op=PASS, a=0x00000001, b=0xFFFFFFFF, inv=0 -> out=0x00000001, parity=1.
- Backpressure: out_ready held low 5 cycles in DONE, second in_valid pulsed meanwhile -> out and flags stable, in_ready=0, second command not accepted. After out_ready, return to IDLE; the next accepted command is correct.
- Reset mid-op: assert rst_n low 2 cycles into RUN -> out_valid=0 and out=0 at once, in_ready=1 after release; the next op AND 0xFFFFFFFF,0x0000FFFF -> 0x0000FFFF, parity=0.
- SLICE=32 and SLICE=4 builds: the same first vector gives an identical result and flags, with latency 1 and 8 cycles respectively.
